// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stage controller.
//   ST_FILL / ST_BFLY / ST_DRAIN : stage datapath mode encoding
//   clog2                        : elaboration-time ceil(log2)
//   cos_q                        : elaboration-time rounded fixed-point cosine
package fft_pkg;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_BFLY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // round_half_away(cos(2*pi*m/n) * 2^frac); constant-folded only
  function automatic int cos_q(input int m, input int n, input int frac);
    real x;
    x = $cos(2.0 * 3.14159265358979323846 * m / n) * (2.0 ** frac);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/fft_sdf_stage_ctrl_if.sv
// Sample handshake and stage-control bundle for one SDF FFT stage.
//   master : sample source (drives in_valid/in_last, observes the rest)
//   slave  : stage controller
interface fft_sdf_stage_ctrl_if #(parameter int TW_W = 24);
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [1:0]             state;
  logic signed [TW_W-1:0] w_r;
  logic signed [TW_W-1:0] w_i;
  logic                   tw_valid;
  logic                   drain_done;

  modport master (output in_valid, in_last,
                  input  in_ready, state, w_r, w_i, tw_valid, drain_done);
  modport slave  (input  in_valid, in_last,
                  output in_ready, state, w_r, w_i, tw_valid, drain_done);
endinterface

// File: rtl/fft_twiddle_rom.sv
// Quarter-wave cosine table with symmetry mapping to full (cos, sin) for
// twiddle index k in [0, N/2). Output is registered; reset value is (1.0, 0).
//   clk, rst_n : clock, async active-low reset
//   k          : twiddle index
//   cos_o      : round(cos(2*pi*k/N) * 2^FRAC)
//   sin_o      : round(sin(2*pi*k/N) * 2^FRAC)
module fft_twiddle_rom import fft_pkg::*; #(
  parameter int N    = 16,
  parameter int TW_W = 24,
  parameter int FRAC = 8,
  localparam int KW  = clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KW-1:0]          k,
  output logic signed [TW_W-1:0] cos_o,
  output logic signed [TW_W-1:0] sin_o
);

  localparam int Q = N / 4;

  // Sized to the full index space so every select is in range; only
  // entries 0..Q are ever addressed.
  logic signed [TW_W-1:0] tbl [0:N-1];

  for (genvar m = 0; m < N; m++) begin : g_tbl
    if (m <= Q) begin : g_used
      assign tbl[m] = TW_W'(cos_q(m, N, FRAC));
    end else begin : g_pad
      assign tbl[m] = '0;
    end
  end

  logic [KW-1:0]          idx_c, idx_s;
  logic                   neg_c;
  logic signed [TW_W-1:0] cos_c, sin_c;

  always_comb begin
    idx_c = k;
    idx_s = KW'(Q) - k;
    neg_c = 1'b0;
    if (k >= KW'(Q)) begin
      // second quadrant: m = k - Q, cos = -C[Q-m], sin = C[m]
      idx_c = KW'(2 * Q) - k;
      idx_s = k - KW'(Q);
      neg_c = 1'b1;
    end
    cos_c = neg_c ? -tbl[idx_c] : tbl[idx_c];
    sin_c = tbl[idx_s];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_o <= TW_W'(1 << FRAC);
      sin_o <= '0;
    end else begin
      cos_o <= cos_c;
      sin_o <= sin_c;
    end
  end

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Controller and twiddle source for one radix-2 SDF FFT stage.
// Tracks the position in the butterfly block, sequences FILL/BFLY/DRAIN,
// and presents the twiddle for the sample leaving the delay line.
// All outputs describe the sample presented in the current cycle, so they
// are registered from next-state values.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of fft_sdf_stage_ctrl_if (handshake + outputs)
// Build option: FFT_SDF_IFFT_CONJ_EN selects conjugate (IFFT) twiddles.
module fft_sdf_stage_ctrl import fft_pkg::*; #(
  parameter int N     = 16,
  parameter int STAGE = 0,
  parameter int TW_W  = 24,
  parameter int FRAC  = 8
) (
  input  logic clk,
  input  logic rst_n,
  fft_sdf_stage_ctrl_if.slave bus
);

  localparam int KW = clog2(N);
  localparam int L  = N >> (STAGE + 1);
  localparam logic [KW-1:0] L_M1  = KW'(L - 1);
  localparam logic [KW-1:0] L2_M1 = KW'(2 * L - 1);

  logic [KW-1:0] pos, pos_n;
  logic [1:0]    fsm, fsm_n;
  logic          primed, primed_n;
  logic          twv, twv_n;
  logic          dd, dd_n;
  logic [KW-1:0] j_n, k_n, rom_k;
  logic signed [TW_W-1:0] cos_w, sin_w;

  always_comb begin
    pos_n    = pos;
    fsm_n    = fsm;
    primed_n = primed;
    case (fsm)
      ST_FILL: if (bus.in_valid) begin
        pos_n = pos + 1'b1;
        if (pos == L_M1) fsm_n = ST_BFLY;
      end
      ST_BFLY: if (bus.in_valid) begin
        if (pos == L2_M1) begin
          pos_n    = '0;
          primed_n = 1'b1;
          fsm_n    = bus.in_last ? ST_DRAIN : ST_FILL;
        end else begin
          pos_n = pos + 1'b1;
        end
      end
      ST_DRAIN: begin
        // self-timed: pos counts drain cycles 0..L-1
        if (pos == L_M1) begin
          pos_n    = '0;
          primed_n = 1'b0;
          fsm_n    = ST_FILL;
        end else begin
          pos_n = pos + 1'b1;
        end
      end
      default: begin
        pos_n    = '0;
        fsm_n    = ST_FILL;
        primed_n = 1'b0;
      end
    endcase

    twv_n = (primed_n && fsm_n == ST_FILL) || fsm_n == ST_DRAIN;
    dd_n  = (fsm_n == ST_DRAIN) && (pos_n == L_M1);
    j_n   = pos_n & L_M1;
    k_n   = j_n << STAGE;
    // k=0 maps exactly to (1.0, 0), which gives the unity override for free
    rom_k = twv_n ? k_n : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= '0;
      fsm    <= ST_FILL;
      primed <= 1'b0;
      twv    <= 1'b0;
      dd     <= 1'b0;
    end else begin
      pos    <= pos_n;
      fsm    <= fsm_n;
      primed <= primed_n;
      twv    <= twv_n;
      dd     <= dd_n;
    end
  end

  fft_twiddle_rom #(.N(N), .TW_W(TW_W), .FRAC(FRAC)) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .k     (rom_k),
    .cos_o (cos_w),
    .sin_o (sin_w)
  );

  assign bus.state      = fsm;
  assign bus.in_ready   = (fsm != ST_DRAIN);
  assign bus.tw_valid   = twv;
  assign bus.drain_done = dd;
  assign bus.w_r        = cos_w;
`ifdef FFT_SDF_IFFT_CONJ_EN
  assign bus.w_i        = sin_w;
`else
  assign bus.w_i        = -sin_w;
`endif

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Directed bench for fft_sdf_stage_ctrl. Three instances share one stimulus:
//   a: N=16 STAGE=0 (L=8), b: N=64 STAGE=2 (L=8, same twiddle values),
//   c: N=64 STAGE=5 (L=1, twiddle always 1.0).
module tb_fft_sdf_stage_ctrl;

`ifdef FFT_SDF_IFFT_CONJ_EN
  localparam bit CONJ = 1'b1;
`else
  localparam bit CONJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // cos/sin(2*pi*j/16) * 256, rounded half away from zero
  int COS [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int SIN [8] = '{0, 98, 181, 237, 256, 237, 181, 98};

  always #5 clk = ~clk;

  fft_sdf_stage_ctrl_if #(.TW_W(24)) ia ();
  fft_sdf_stage_ctrl_if #(.TW_W(24)) ib ();
  fft_sdf_stage_ctrl_if #(.TW_W(24)) ic ();

  assign ia.in_valid = in_valid;
  assign ia.in_last  = in_last;
  assign ib.in_valid = in_valid;
  assign ib.in_last  = in_last;
  assign ic.in_valid = in_valid;
  assign ic.in_last  = in_last;

  fft_sdf_stage_ctrl #(.N(16), .STAGE(0), .TW_W(24), .FRAC(8)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  fft_sdf_stage_ctrl #(.N(64), .STAGE(2), .TW_W(24), .FRAC(8)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));
  fft_sdf_stage_ctrl #(.N(64), .STAGE(5), .TW_W(24), .FRAC(8)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(ic));

  // expected {state, in_ready, tw_valid, drain_done, w_r, w_i}
  function automatic logic [52:0] ev(input logic [1:0] st, input logic tv,
                                     input logic dd, input int j);
    int wr, wi;
    wr = tv ? COS[j] : 256;
    wi = tv ? (CONJ ? SIN[j] : -SIN[j]) : 0;
    return {st, st != 2'd2, tv, dd, wr[23:0], wi[23:0]};
  endfunction

  logic [52:0] oa, ob, ex;
  logic [47:0] oc;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    oa = {ia.state, ia.in_ready, ia.tw_valid, ia.drain_done, ia.w_r, ia.w_i};
    ob = {ib.state, ib.in_ready, ib.tw_valid, ib.drain_done, ib.w_r, ib.w_i};
    oc = {ic.w_r, ic.w_i};
    ex = ev(2'd0, 1'b0, 1'b0, 0);
    checks++;
    if (oa !== ex || ob !== ex || oc !== 48'h000100_000000) begin
      errors++;
      $display("FAIL reset a=%h b=%h c=%h expected=%h", oa, ob, oc, ex);
    end
    rst_n = 1'b1;
  endtask

  // One 16-sample block. fill_tw: delay line is primed, so FILL carries
  // twiddles. last: in_last on sample 15; otherwise in_last is pulsed on
  // sample 3 where it must be ignored. gaps: random in_valid holes.
  task automatic test_stream(input string name, input bit fill_tw,
                             input bit last, input bit gaps);
    int i = 0;
    int cyc = 0;
    logic v;
    while (i < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v;
      in_last  = last ? (i == 15) : (i == 3);
      oa = {ia.state, ia.in_ready, ia.tw_valid, ia.drain_done, ia.w_r, ia.w_i};
      ob = {ib.state, ib.in_ready, ib.tw_valid, ib.drain_done, ib.w_r, ib.w_i};
      oc = {ic.w_r, ic.w_i};
      ex = ev((i < 8) ? 2'd0 : 2'd1, fill_tw && (i < 8), 1'b0, i % 8);
      checks++;
      if (oa !== ex || ob !== ex || oc !== 48'h000100_000000) begin
        errors++;
        $display("FAIL %s pos=%0d a=%h b=%h c=%h expected=%h", name, i, oa, ob, oc, ex);
      end
      if (v) i++;
    end
    checks++;
    if (i != 16) begin
      errors++;
      $display("FAIL %s_budget accepted=%0d expected=16", name, i);
    end
  endtask

  task automatic test_drain();
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      in_valid = d[0];
      in_last  = 1'b0;
      oa = {ia.state, ia.in_ready, ia.tw_valid, ia.drain_done, ia.w_r, ia.w_i};
      ob = {ib.state, ib.in_ready, ib.tw_valid, ib.drain_done, ib.w_r, ib.w_i};
      oc = {ic.w_r, ic.w_i};
      ex = ev(2'd2, 1'b1, d == 7, d);
      checks++;
      if (oa !== ex || ob !== ex || oc !== 48'h000100_000000) begin
        errors++;
        $display("FAIL drain cyc=%0d a=%h b=%h c=%h expected=%h", d, oa, ob, oc, ex);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = 1'b0;
    end
    @(negedge clk);
    oa = {ia.state, ia.in_ready, ia.tw_valid, ia.drain_done, ia.w_r, ia.w_i};
    ex = ev(2'd1, 1'b0, 1'b0, 0);
    checks++;
    if (oa !== ex) begin
      errors++;
      $display("FAIL bfly_pos11 a=%h expected=%h", oa, ex);
    end
    #2 rst_n = 1'b0;
    #1;
    oa = {ia.state, ia.in_ready, ia.tw_valid, ia.drain_done, ia.w_r, ia.w_i};
    ob = {ib.state, ib.in_ready, ib.tw_valid, ib.drain_done, ib.w_r, ib.w_i};
    ex = ev(2'd0, 1'b0, 1'b0, 0);
    checks++;
    if (oa !== ex || ob !== ex) begin
      errors++;
      $display("FAIL async_reset a=%h b=%h expected=%h", oa, ob, ex);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream("first_block", 1'b0, 1'b0, 1'b0);
    test_stream("second_block", 1'b1, 1'b1, 1'b0);
    test_drain();
    test_stream("back_to_back", 1'b0, 1'b0, 1'b0);
    test_stream("gaps_primed", 1'b1, 1'b0, 1'b1);
    test_stream("gaps_primed2", 1'b1, 1'b0, 1'b1);
    test_reset_mid();
    test_stream("post_reset", 1'b0, 1'b0, 1'b0);
    test_stream("post_reset2", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
